// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 frame receiver.
//   ps2_state_t      : receive FSM state encoding
//   PS2_DATA_BITS    : payload bits per frame
//   PS2_FRAME_BITS   : total bits per frame (start + data + parity + stop)
//   odd_parity_ok()  : 1 when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                          input logic                     par);
      return (^data) ^ par;
   endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if -- received-byte stream plus error pulses.
//   sym_data   : byte at the FIFO head
//   sym_valid  : sym_data holds a byte
//   sym_ready  : consumer takes the head byte when high with sym_valid
//   parity_err : one-cycle pulse, frame dropped for bad odd parity
//   frame_err  : one-cycle pulse, bad start/stop bit or timeout
//   overflow   : one-cycle pulse, good byte dropped because FIFO was full
// master = receiver side, slave = consumer side.
interface ps2_frame_rx_if;
   import ps2_pkg::*;

   logic [PS2_DATA_BITS-1:0] sym_data;
   logic                     sym_valid;
   logic                     sym_ready;
   logic                     parity_err;
   logic                     frame_err;
   logic                     overflow;

   modport master (
      output sym_data, sym_valid, parity_err, frame_err, overflow,
      input  sym_ready
   );

   modport slave (
      input  sym_data, sym_valid, parity_err, frame_err, overflow,
      output sym_ready
   );
endinterface

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo -- first-word-fall-through FIFO.
//   clk48, rst_n : clock, asynchronous active-low reset
//   push         : write push_data this cycle
//   push_data    : data to write
//   pop_req      : consumer ready; a pop happens when the FIFO is non-empty
//   rd_data      : head entry (0 while empty)
//   rd_valid     : FIFO non-empty
//   drop         : push rejected this cycle (full and no simultaneous pop)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module ps2_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk48,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_req,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop_req & ~empty;
   // A pop in the same cycle frees the slot the push lands in, even when full.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   // Masked so the output reads 0 while empty rather than stale contents.
   assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
   assign rd_valid = ~empty;

   always_ff @(posedge clk48) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- PS/2 keyboard frame receiver with byte FIFO.
//   clk48      : sole clock
//   rst_n      : asynchronous active-low reset
//   device_clk : raw PS/2 clock (asynchronous)
//   device_dat : raw PS/2 data (asynchronous)
//   sym_if     : byte stream and error pulses (master side)
// Both PS/2 lines are synchronized, the clock is glitch-filtered, and each
// filtered falling edge advances the IDLE/DATA/PARITY/STOP frame FSM.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 48000000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 96000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic           clk48,
   input  logic           rst_n,
   input  logic           device_clk,
   input  logic           device_dat,
   ps2_frame_rx_if.master sym_if
);
   // A TIMEOUT_CYCLES of 0 derives a 2 ms timeout from the clock frequency.
   localparam int TMO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : CLK_HZ / 500;
   localparam int TCW       = $clog2(TMO_LIMIT + 1);
   localparam int FCW       = $clog2(FILTER_LEN + 1);
   localparam int BCW       = $clog2(PS2_DATA_BITS);

   logic [1:0]               raw_in;
   logic [1:0]               sync_in;
   logic                     clk_s;
   logic                     dat_s;
   logic                     filt_clk_reg;
   logic                     filt_prev_reg;
   logic [FCW-1:0]           filt_cnt_reg;
   logic                     fall;
   ps2_state_t               state_reg;
   logic [BCW-1:0]           bit_cnt_reg;
   logic [PS2_DATA_BITS-1:0] shift_reg;
   logic                     par_reg;
   logic [TCW-1:0]           tmo_cnt_reg;
   logic                     push_reg;
   logic                     parity_err_reg;
   logic                     frame_err_reg;
   logic                     overflow_reg;
   logic [PS2_DATA_BITS-1:0] fifo_data;
   logic                     fifo_valid;
   logic                     fifo_drop;

   assign raw_in = {device_dat, device_clk};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         always_ff @(posedge clk48 or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= raw_in[gi];
               sync_reg <= meta_reg;
            end
         end
         assign sync_in[gi] = sync_reg;
      end
   endgenerate

   assign clk_s = sync_in[0];
   assign dat_s = sync_in[1];

   // The counter only advances while the synchronized clock disagrees with the
   // filtered level; any sample back at the old level restarts the run.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         filt_clk_reg  <= 1'b1;
         filt_prev_reg <= 1'b1;
         filt_cnt_reg  <= '0;
      end else begin
         filt_prev_reg <= filt_clk_reg;
         if (clk_s == filt_clk_reg) begin
            filt_cnt_reg <= '0;
         end else if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_clk_reg <= clk_s;
            filt_cnt_reg <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + FCW'(1);
         end
      end
   end

   assign fall = filt_prev_reg & ~filt_clk_reg;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         par_reg        <= 1'b0;
         tmo_cnt_reg    <= '0;
         push_reg       <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         push_reg       <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         if (state_reg == ST_IDLE) begin
            tmo_cnt_reg <= '0;
            if (fall) begin
               if (!dat_s) begin
                  state_reg   <= ST_DATA;
                  bit_cnt_reg <= '0;
               end else begin
                  frame_err_reg <= 1'b1;
               end
            end
         end else if (fall) begin
            tmo_cnt_reg <= '0;
            case (state_reg)
               ST_DATA: begin
                  shift_reg   <= {dat_s, shift_reg[PS2_DATA_BITS-1:1]};
                  bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                  if (bit_cnt_reg == BCW'(PS2_DATA_BITS - 1)) begin
                     state_reg <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  par_reg   <= dat_s;
                  state_reg <= ST_STOP;
               end
               ST_STOP: begin
                  state_reg <= ST_IDLE;
                  // A bad stop bit takes precedence over a parity error.
                  if (!dat_s) begin
                     frame_err_reg <= 1'b1;
                  end else if (!odd_parity_ok(shift_reg, par_reg)) begin
                     parity_err_reg <= 1'b1;
                  end else begin
                     push_reg <= 1'b1;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end else if (tmo_cnt_reg == TCW'(TMO_LIMIT - 1)) begin
            state_reg     <= ST_IDLE;
            tmo_cnt_reg   <= '0;
            frame_err_reg <= 1'b1;
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TCW'(1);
         end
      end
   end

   // shift_reg still holds the byte in the cycle after the stop edge.
   ps2_byte_fifo #(
      .WIDTH (PS2_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .push      (push_reg),
      .push_data (shift_reg),
      .pop_req   (sym_if.sym_ready),
      .rd_data   (fifo_data),
      .rd_valid  (fifo_valid),
      .drop      (fifo_drop)
   );

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= fifo_drop;
      end
   end

   assign sym_if.sym_data   = fifo_data;
   assign sym_if.sym_valid  = fifo_valid;
   assign sym_if.parity_err = parity_err_reg;
   assign sym_if.frame_err  = frame_err_reg;
   assign sym_if.overflow   = overflow_reg;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx -- directed frames against a queue-based model of the
// receiver's observable behaviour; one compare process checks every cycle.
module tb_ps2_frame_rx;
   import ps2_pkg::*;

   localparam int HALF  = 40;     // PS/2 half bit period in clk48 cycles
   localparam int FLEN  = 8;
   localparam int TMO   = 2000;
   localparam int DEPTH = 4;
   localparam int K_GOOD = 0;
   localparam int K_PAR  = 1;
   localparam int K_FRM  = 2;
   // Edge detection: 2 sync stages + FILTER_LEN filter samples, then the FSM edge.
   localparam int LAT_PULSE = FLEN + 3;
   localparam int LAT_PUSH  = FLEN + 4;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic clk48 = 1'b0;
   logic rst_n = 1'b0;
   logic device_clk = 1'b1;
   logic device_dat = 1'b1;
   int   cyc = 0;

   ps2_frame_rx_if sym_if ();

   ps2_frame_rx #(
      .CLK_HZ         (48000000),
      .FILTER_LEN     (FLEN),
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk48      (clk48),
      .rst_n      (rst_n),
      .device_clk (device_clk),
      .device_dat (device_dat),
      .sym_if     (sym_if)
   );

   always #10 clk48 = ~clk48;
   always @(posedge clk48) cyc <= cyc + 1;

   ev_t        sched[$];
   logic [7:0] model_q[$];
   bit         exp_par = 0;
   bit         exp_frm = 0;
   bit         exp_ovf = 0;
   int         checks = 0;
   int         errors = 0;
   int         n_par = 0;
   int         n_frm = 0;
   int         n_ovf = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Compare this cycle's outputs, then advance the model to the next cycle.
   always @(negedge clk48) begin : compare
      bit  pop;
      int  occ;
      ev_t keep[$];
      if (!rst_n) begin
         model_q.delete();
         sched.delete();
         exp_par = 0;
         exp_frm = 0;
         exp_ovf = 0;
      end
      check("sym_valid", int'(sym_if.sym_valid), (model_q.size() > 0) ? 1 : 0);
      check("sym_data", int'(sym_if.sym_data), (model_q.size() > 0) ? int'(model_q[0]) : 0);
      check("parity_err", int'(sym_if.parity_err), int'(exp_par));
      check("frame_err", int'(sym_if.frame_err), int'(exp_frm));
      check("overflow", int'(sym_if.overflow), int'(exp_ovf));
      n_par += int'(sym_if.parity_err);
      n_frm += int'(sym_if.frame_err);
      n_ovf += int'(sym_if.overflow);
      if (rst_n) begin
         occ = model_q.size();
         pop = sym_if.sym_ready && (occ > 0);
         exp_par = 0;
         exp_frm = 0;
         exp_ovf = 0;
         if (pop) void'(model_q.pop_front());
         keep = {};
         foreach (sched[i]) begin
            if (sched[i].cyc > cyc + 1) begin
               keep.push_back(sched[i]);
            end else if (sched[i].cyc == cyc + 1) begin
               case (sched[i].kind)
                  K_PAR:   exp_par = 1;
                  K_FRM:   exp_frm = 1;
                  default: begin
                     if (occ < DEPTH || pop) model_q.push_back(sched[i].data);
                     else exp_ovf = 1;
                  end
               endcase
            end
         end
         sched = keep;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk48);
      #1;
   endtask

   task automatic add_ev(input int at, input int kind, input logic [7:0] d);
      ev_t e;
      e.cyc  = at;
      e.kind = kind;
      e.data = d;
      sched.push_back(e);
   endtask

   // Sends start, data LSB-first, parity and stop; nfalls < 11 abandons the frame.
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit,
                             input int nfalls, input bit glitch, input bit ready_on_push,
                             input bit exp_timeout);
      logic [10:0] bits;
      int          c0;
      logic        par;
      par  = bad_par ? (^d) : ~(^d);
      bits = {stop_bit, par, d, 1'b0};
      c0   = 0;
      $display("frame data=0x%02h parity=%0b stop=%0b falls=%0d glitch=%0b", d, par, stop_bit, nfalls, glitch);
      if (glitch) begin
         wait_cyc(10);
         device_clk = 1'b0;
         wait_cyc(3);
         device_clk = 1'b1;
      end
      for (int b = 0; b < nfalls; b++) begin
         wait_cyc(HALF / 2);
         device_dat = bits[b];
         if (glitch) begin
            wait_cyc(5);
            device_clk = 1'b0;
            wait_cyc(3);
            device_clk = 1'b1;
            wait_cyc(HALF / 2 - 8);
         end else begin
            wait_cyc(HALF / 2);
         end
         device_clk = 1'b0;
         c0 = cyc;
         if (b == 10) begin
            if (!stop_bit)                 add_ev(c0 + LAT_PULSE, K_FRM, d);
            else if (bad_par)              add_ev(c0 + LAT_PULSE, K_PAR, d);
            else                           add_ev(c0 + LAT_PUSH, K_GOOD, d);
         end
         for (int i = 0; i < HALF; i++) begin
            wait_cyc(1);
            if (ready_on_push && b == 10 && i == LAT_PUSH - 2) sym_if.sym_ready = 1'b1;
            if (ready_on_push && b == 10 && i == LAT_PUSH - 1) sym_if.sym_ready = 1'b0;
            if (glitch && i == 15) device_clk = 1'b1;
            if (glitch && i == 18) device_clk = 1'b0;
         end
         device_clk = 1'b1;
      end
      if (exp_timeout) add_ev(c0 + LAT_PULSE + TMO, K_FRM, d);
      device_dat = 1'b1;
   endtask

   task automatic pop_one();
      sym_if.sym_ready = 1'b1;
      wait_cyc(1);
      sym_if.sym_ready = 1'b0;
      wait_cyc(1);
   endtask

   initial begin
      logic [7:0] exp_order[4];
      exp_order = '{8'h02, 8'h03, 8'h04, 8'h06};
      sym_if.sym_ready = 1'b0;
      wait_cyc(5);
      check("reset_valid", int'(sym_if.sym_valid), 0);
      rst_n = 1'b1;
      wait_cyc(20);

      // Single good byte.
      send_frame(8'h1C, 0, 1, 11, 0, 0, 0);
      wait_cyc(20);
      check("t1_data", int'(sym_if.sym_data), 'h1C);
      check("t1_model_size", model_q.size(), 1);
      check("t1_no_errors", n_par + n_frm + n_ovf, 0);
      pop_one();
      check("t1_drained", int'(sym_if.sym_valid), 0);

      // Bad parity, then bad stop bit.
      send_frame(8'hF0, 1, 1, 11, 0, 0, 0);
      wait_cyc(20);
      check("t2_parity_count", n_par, 1);
      check("t2_no_write", int'(sym_if.sym_valid), 0);
      send_frame(8'h5A, 0, 0, 11, 0, 0, 0);
      wait_cyc(20);
      check("t2_frame_count", n_frm, 1);
      check("t2_parity_still", n_par, 1);

      // Overflow, then simultaneous push and pop while full.
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 1, 11, 0, 0, 0);
      wait_cyc(20);
      check("t3_overflow_count", n_ovf, 1);
      check("t3_head", int'(sym_if.sym_data), 'h01);
      send_frame(8'h06, 0, 1, 11, 0, 1, 0);
      wait_cyc(20);
      check("t3_no_new_overflow", n_ovf, 1);
      for (int i = 0; i < 4; i++) begin
         check("t3_order", int'(sym_if.sym_data), int'(exp_order[i]));
         pop_one();
      end
      check("t3_empty", int'(sym_if.sym_valid), 0);

      // Timeout after 4 data bits, then a clean frame.
      send_frame(8'h55, 0, 1, 5, 0, 0, 1);
      wait_cyc(2500);
      check("t4_timeout_count", n_frm, 2);
      send_frame(8'h29, 0, 1, 11, 0, 0, 0);
      wait_cyc(20);
      check("t4_data", int'(sym_if.sym_data), 'h29);
      pop_one();

      // Glitches in idle and within bits.
      send_frame(8'h33, 0, 1, 11, 1, 0, 0);
      wait_cyc(20);
      check("t5_data", int'(sym_if.sym_data), 'h33);
      check("t5_frame_count", n_frm, 2);

      // Reset mid-frame with a byte still buffered.
      send_frame(8'hAB, 0, 1, 6, 0, 0, 0);
      wait_cyc(5);
      rst_n = 1'b0;
      wait_cyc(3);
      check("t6_reset_valid", int'(sym_if.sym_valid), 0);
      check("t6_reset_data", int'(sym_if.sym_data), 0);
      rst_n = 1'b1;
      wait_cyc(HALF);
      send_frame(8'h12, 0, 1, 11, 0, 0, 0);
      wait_cyc(20);
      check("t6_data", int'(sym_if.sym_data), 'h12);
      check("t6_final_par", n_par, 1);
      check("t6_final_frm", n_frm, 2);
      check("t6_final_ovf", n_ovf, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
